// File: rtl/snn_train_scheduler.sv
// Training/inference sequencer for the 25-in/10-out spiking classifier.
// Optional macro SNN_SCHED_SHUFFLE_EN rotates the training order per epoch via a 4-bit LFSR.
module snn_spike_ctr #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (clr)                  cnt <= '0;
    else if (inc && (cnt != '1))   cnt <= cnt + 1'b1;
  end
endmodule

module snn_train_scheduler #(
  parameter int         NUM_PATTERNS   = 10,
  parameter int         PRESENT_CYCLES = 200,
  parameter int         REST_CYCLES    = 50,
  parameter int         EPOCHS         = 20,
  parameter int         CNT_W          = 8,
  parameter logic [3:0] BLANK_CODE     = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [9:0]       spike,
  output logic [3:0]       in_cnt,
  output logic             learn,
  output logic             busy,
  output logic             result_valid,
  output logic [3:0]       result_pattern,
  output logic [3:0]       result_neuron,
  output logic [CNT_W-1:0] result_count,
  output logic             done
);
  localparam int NUM_NEURONS = 10;
  localparam int LEN_A   = (PRESENT_CYCLES > REST_CYCLES) ? PRESENT_CYCLES : REST_CYCLES;
  localparam int MAX_LEN = (LEN_A > NUM_NEURONS) ? LEN_A : NUM_NEURONS;
  localparam int CYC_W   = $clog2(MAX_LEN);
  localparam int EP_W    = (EPOCHS > 1) ? $clog2(EPOCHS) : 1;

  typedef enum logic [2:0] {IDLE, T_PRES, T_REST, I_PRES, EVAL, REPORT, I_REST} state_t;

  typedef struct packed {
    logic [3:0]       pattern;
    logic [3:0]       neuron;
    logic [CNT_W-1:0] count;
  } result_t;

  state_t     state, state_d;
  logic [CYC_W-1:0] cyc, cyc_d;
  logic [3:0] pat, pat_d, train_idx;
  logic [EP_W-1:0] epoch, ep_d;
  logic       done_d, learn_d;
  logic [3:0] in_cnt_d;
  logic       last_pres, last_rest, last_eval, last_pat, last_ep;

  logic [NUM_NEURONS-1:0][CNT_W-1:0] cnt;
  logic       ctr_clr, ctr_en;
  logic [3:0] scan, best_idx, nb_idx;
  logic [CNT_W-1:0] best_cnt, nb_cnt, cur_cnt;
  result_t    res_q;

  assign last_pres = (cyc == CYC_W'(PRESENT_CYCLES - 1));
  assign last_rest = (cyc == CYC_W'(REST_CYCLES - 1));
  assign last_eval = (cyc == CYC_W'(NUM_NEURONS - 1));
  assign last_pat  = (pat == 4'(NUM_PATTERNS - 1));
  assign last_ep   = (epoch == EP_W'(EPOCHS - 1));

  always_comb begin
    state_d = state;
    cyc_d   = cyc + 1'b1;
    pat_d   = pat;
    ep_d    = epoch;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        cyc_d = '0;
        if (start) begin
          pat_d   = '0;
          ep_d    = '0;
          state_d = (EPOCHS == 0) ? I_PRES : T_PRES;
        end
      end
      T_PRES: if (last_pres) begin state_d = T_REST; cyc_d = '0; end
      T_REST: begin
        if (last_rest) begin
          cyc_d   = '0;
          state_d = T_PRES;
          if (last_pat) begin
            pat_d = '0;
            if (last_ep) begin
              state_d = I_PRES;
              ep_d    = '0;
            end else begin
              ep_d = epoch + 1'b1;
            end
          end else begin
            pat_d = pat + 1'b1;
          end
        end
      end
      I_PRES: if (last_pres) begin state_d = EVAL; cyc_d = '0; end
      EVAL:   if (last_eval) begin state_d = REPORT; cyc_d = '0; end
      REPORT: begin state_d = I_REST; cyc_d = '0; end
      I_REST: begin
        if (last_rest) begin
          cyc_d = '0;
          if (last_pat) begin
            state_d = IDLE;
            pat_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = I_PRES;
            pat_d   = pat + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SNN_SCHED_SHUFFLE_EN
  // Rotation offset steps at each epoch boundary, so the next epoch's first index already uses it.
  logic [3:0] lfsr, lfsr_d;
  logic [4:0] rot_sum;
  always_comb begin
    lfsr_d = lfsr;
    if (state == T_REST && last_rest && last_pat) lfsr_d = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 4'b1001;
    else        lfsr <= lfsr_d;
  end
  assign rot_sum   = {1'b0, pat_d} + {1'b0, lfsr_d};
  assign train_idx = 4'(rot_sum % 5'(NUM_PATTERNS));
`else
  assign train_idx = pat_d;
`endif

  always_comb begin
    in_cnt_d = BLANK_CODE;
    learn_d  = 1'b0;
    if (state_d == T_PRES) begin
      in_cnt_d = train_idx;
      learn_d  = 1'b1;
    end else if (state_d == I_PRES) begin
      in_cnt_d = pat_d;
    end
  end

  assign ctr_clr = (state_d == I_PRES) && (state != I_PRES);
  assign ctr_en  = (state == I_PRES);

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_ctr
    snn_spike_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (ctr_clr),
      .inc  (ctr_en & spike[n]),
      .cnt  (cnt[n])
    );
  end

  // Strictly-greater compare keeps the lowest index on ties; a zero best stays at 4'hF.
  assign scan    = cyc[3:0];
  assign cur_cnt = (scan < 4'(NUM_NEURONS)) ? cnt[scan] : '0;
  assign nb_idx  = (cur_cnt > best_cnt) ? scan : best_idx;
  assign nb_cnt  = (cur_cnt > best_cnt) ? cur_cnt : best_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cyc          <= '0;
      pat          <= '0;
      epoch        <= '0;
      in_cnt       <= BLANK_CODE;
      learn        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      best_idx     <= 4'hF;
      best_cnt     <= '0;
      result_valid <= 1'b0;
      res_q        <= '{pattern: 4'h0, neuron: 4'hF, count: '0};
    end else begin
      state        <= state_d;
      cyc          <= cyc_d;
      pat          <= pat_d;
      epoch        <= ep_d;
      in_cnt       <= in_cnt_d;
      learn        <= learn_d;
      busy         <= (state_d != IDLE);
      done         <= done_d;
      result_valid <= 1'b0;
      if (state == I_PRES) begin
        best_idx <= 4'hF;
        best_cnt <= '0;
      end else if (state == EVAL) begin
        best_idx <= nb_idx;
        best_cnt <= nb_cnt;
      end
      if (state == EVAL && last_eval) begin
        result_valid <= 1'b1;
        res_q        <= '{pattern: pat, neuron: nb_idx, count: nb_cnt};
      end
    end
  end

  assign result_pattern = res_q.pattern;
  assign result_neuron  = res_q.neuron;
  assign result_count   = res_q.count;
endmodule

// File: tb/tb_snn_train_scheduler.sv
// Self-checking bench: cycle-accurate expected schedule built from the phase rules plus a spike-count model.
module tb_snn_train_scheduler;
  localparam int P = 4, R = 2, N = 3, E = 2, CW = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [9:0] spike = '0;
  logic [3:0] in_cnt, result_pattern, result_neuron;
  logic learn, busy, result_valid, done;
  logic [CW-1:0] result_count;

  logic s_start = 1'b0;
  logic [9:0] s_spike = '0;
  logic [3:0] s_in_cnt, s_result_pattern, s_result_neuron;
  logic s_learn, s_busy, s_result_valid, s_done;
  logic [CW-1:0] s_result_count;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  snn_train_scheduler #(.NUM_PATTERNS(N), .PRESENT_CYCLES(P), .REST_CYCLES(R), .EPOCHS(E),
                        .CNT_W(CW), .BLANK_CODE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .spike(spike), .in_cnt(in_cnt), .learn(learn),
    .busy(busy), .result_valid(result_valid), .result_pattern(result_pattern),
    .result_neuron(result_neuron), .result_count(result_count), .done(done));

  snn_train_scheduler #(.NUM_PATTERNS(2), .PRESENT_CYCLES(20), .REST_CYCLES(2), .EPOCHS(0),
                        .CNT_W(CW), .BLANK_CODE(4'hF)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .spike(s_spike), .in_cnt(s_in_cnt), .learn(s_learn),
    .busy(s_busy), .result_valid(s_result_valid), .result_pattern(s_result_pattern),
    .result_neuron(s_result_neuron), .result_count(s_result_count), .done(s_done));

  typedef struct packed {
    logic [3:0] in_cnt;
    logic learn, busy, rv, done;
  } obs_t;

  obs_t exp_q[$];
  int   kind_q[$];   // p*100+pos during an inference presentation, else -1
  int   mcnt[N][10];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic build_model();
    int lf;
    bit shuf;
    lf = 9;
    shuf = 1'b0;
`ifdef SNN_SCHED_SHUFFLE_EN
    shuf = 1'b1;
`endif
    exp_q.delete();
    kind_q.delete();
    for (int e = 0; e < E; e++) begin
      for (int i = 0; i < N; i++) begin
        int p;
        p = shuf ? (i + lf) % N : i;
        repeat (P) begin exp_q.push_back('{4'(p), 1'b1, 1'b1, 1'b0, 1'b0}); kind_q.push_back(-1); end
        repeat (R) begin exp_q.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 1'b0}); kind_q.push_back(-1); end
      end
      lf = ((lf << 1) & 15) | (((lf >> 3) ^ (lf >> 2)) & 1);
    end
    for (int p = 0; p < N; p++) begin
      for (int k = 0; k < P; k++) begin
        exp_q.push_back('{4'(p), 1'b0, 1'b1, 1'b0, 1'b0}); kind_q.push_back(p * 100 + k);
      end
      repeat (10) begin exp_q.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 1'b0}); kind_q.push_back(-1); end
      exp_q.push_back('{4'hF, 1'b0, 1'b1, 1'b1, 1'b0}); kind_q.push_back(-1);
      repeat (R) begin exp_q.push_back('{4'hF, 1'b0, 1'b1, 1'b0, 1'b0}); kind_q.push_back(-1); end
    end
    exp_q.push_back('{4'hF, 1'b0, 1'b0, 1'b0, 1'b1}); kind_q.push_back(-1);
  endtask

  initial begin
    int rp, bi, bc, rv_n, dn_n;
    logic [9:0] sp;

    // 1: reset and idle
    repeat (3) @(negedge clk);
    chk("reset_vals", {in_cnt, learn, busy, result_valid, done, result_pattern, result_neuron, result_count},
        {4'hF, 4'b0000, 4'h0, 4'hF, 4'h0});
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("idle", {in_cnt, learn, busy, result_valid, done, result_neuron}, {4'hF, 4'b0000, 4'hF});
    end

    // 2,3,5a: full run with random/tie/silent patterns and a start pulse during rest
    build_model();
    for (int p = 0; p < N; p++) for (int n = 0; n < 10; n++) mcnt[p][n] = 0;
    rp = 0;
    start = 1'b1;
    @(posedge clk);
    for (int t = 0; t < exp_q.size(); t++) begin
      @(negedge clk);
      start = (t + 1 == 5);
      chk($sformatf("seq_c%0d", t + 1), {in_cnt, learn, busy, result_valid, done}, exp_q[t]);
      if (exp_q[t].rv) begin
        bi = 15; bc = 0;
        for (int n = 0; n < 10; n++) if (mcnt[rp][n] > bc) begin bc = mcnt[rp][n]; bi = n; end
        chk($sformatf("res_pat%0d", rp), {result_pattern, result_neuron, result_count},
            {4'(rp), 4'(bi), 4'(bc)});
        rp++;
      end
      sp = '0;
      if (kind_q[t] >= 0) begin
        if (kind_q[t] / 100 == 0)      sp = 10'($urandom_range(0, 1023));
        else if (kind_q[t] / 100 == 1) sp = (kind_q[t] % 100 < 3) ? 10'h088 : 10'h000;
        for (int n = 0; n < 10; n++)
          if (sp[n] && mcnt[kind_q[t] / 100][n] < 15) mcnt[kind_q[t] / 100][n]++;
      end
      spike = sp;
    end
    spike = '0;
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_idle", {in_cnt, learn, busy, result_valid, done}, {4'hF, 4'b0000});
    end
    chk("tie_result_held", {result_pattern, result_neuron, result_count}, {4'(N - 1), 4'hF, 4'h0});

    // 5b: asynchronous reset during I_PRES
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c >= 36) chk($sformatf("rerun_c%0d", c), {in_cnt, learn, busy, result_valid, done}, exp_q[c - 1]);
    end
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {busy, in_cnt, learn, done, result_valid}, {1'b0, 4'hF, 3'b000});
    chk("async_rst_res", {result_pattern, result_neuron, result_count}, {4'h0, 4'hF, 4'h0});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("in_rst", {busy, done, in_cnt}, {2'b00, 4'hF});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("after_rst", {busy, done, learn, in_cnt}, {3'b000, 4'hF});
    end

    // 4: saturation and no-spike pattern on the EPOCHS=0 instance
    rv_n = 0; dn_n = 0;
    s_start = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 80; t++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (t == 1)  chk("sat_first", {s_in_cnt, s_learn, s_busy}, {4'h0, 1'b0, 1'b1});
      if (t == 31) chk("sat_res", {s_result_valid, s_result_pattern, s_result_neuron, s_result_count},
                       {1'b1, 4'h0, 4'h9, 4'hF});
      if (t == 64) chk("none_res", {s_result_valid, s_result_pattern, s_result_neuron, s_result_count},
                       {1'b1, 4'h1, 4'hF, 4'h0});
      if (t == 67) chk("sat_done", {s_done, s_busy}, {1'b1, 1'b0});
      if (s_result_valid) rv_n++;
      if (s_done) dn_n++;
      s_spike = (t <= 20) ? (10'h200 | ((t <= 5) ? 10'h004 : 10'h000)) : 10'h000;
    end
    chk("sat_rv_pulses", 64'(rv_n), 64'd2);
    chk("sat_done_pulses", 64'(dn_n), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/snn_train_scheduler.md
# snn_train_scheduler

Sequencer for the 25-input / 10-output spiking classifier array. It runs a training phase: each pattern index is presented on `in_cnt` with `learn` high, followed by a blank rest interval, for a programmed number of epochs. It then runs an inference pass: each pattern is presented with `learn` low, output spikes are counted per neuron, and the winning neuron for each pattern is reported. It sits above the classifier top level and drives its `in_cnt` and `learn` inputs from a single start pulse.

## Interface

**Parameters**
- `NUM_PATTERNS`, 10 — pattern indices 0..NUM_PATTERNS-1; legal range 1..15.
- `PRESENT_CYCLES`, 200 — cycles per presentation; minimum 1.
- `REST_CYCLES`, 50 — cycles per rest interval; minimum 1.
- `EPOCHS`, 20 — training passes over all patterns; 0 skips training.
- `CNT_W`, 8 — spike counter width.
- `BLANK_CODE`, 4'hF — `in_cnt` value driven during rest (the blank pattern).

**Ports**
- `clk` in 1 — clock.
- `rst_n` in 1 — reset. One clock; reset is asynchronous and active-low.
- `start` in 1 — run request; sampled in IDLE only.
- `spike` in 10 — output-neuron spikes from the classifier.
- `in_cnt` out 4 — pattern index to the classifier.
- `learn` out 1 — plasticity enable to the classifier.
- `busy` out 1 — high in every state except IDLE.
- `result_valid` out 1 — one-cycle pulse per inferred pattern.
- `result_pattern` out 4 — pattern index of the current result.
- `result_neuron` out 4 — winning neuron 0..9; 4'hF if no spikes.
- `result_count` out CNT_W — spike count of the winner.
- `done` out 1 — one-cycle pulse when the inference pass completes.

## Operation

**States and transitions**
- IDLE → T_PRES on `start`; skip to I_PRES when EPOCHS=0.
- T_PRES → T_REST after PRESENT_CYCLES cycles.
- T_REST → T_PRES with the next pattern, or → I_PRES after the last pattern of the last epoch.
- I_PRES → EVAL after PRESENT_CYCLES cycles.
- EVAL: scans 10 cycles, then → REPORT.
- REPORT: 1 cycle, then → I_REST.
- I_REST → I_PRES with the next pattern, or → IDLE with `done` after pattern NUM_PATTERNS-1.

**Outputs by state**
- T_PRES: `learn`=1, `in_cnt`=pattern.
- I_PRES: `learn`=0, `in_cnt`=pattern.
- T_REST, I_REST, EVAL, REPORT: `learn`=0, `in_cnt`=BLANK_CODE.
- IDLE: `learn`=0, `in_cnt`=BLANK_CODE.

**Spike counting and winner selection**
- Spike counters: ten CNT_W counters, cleared on entry to I_PRES.
- A counter increments on each cycle its `spike` bit is high in I_PRES only.
- Counters saturate at 2^CNT_W-1.
- EVAL scans neuron 0..9, one neuron per cycle, keeping the best index and count.
- The scan replaces the best only on strictly greater, so ties resolve to the lowest index.
- A best count of 0 yields neuron 4'hF, count 0.
- Results are registered in REPORT and held until the next REPORT.

**Start and reset**
- `start` while busy is ignored.
- No abort exists other than `rst_n`.
- Reset mid-run returns to IDLE immediately (asynchronous).
- Reset clears all counters, epoch and pattern indices, and results.

## Timing

**Reset values**
- `in_cnt`=BLANK_CODE.
- `learn`, `busy`, `result_valid`, `done` = 0.
- `result_pattern` = 0, `result_neuron` = 4'hF, `result_count` = 0.

**Latency**
- `start` high in IDLE at edge k: at edge k+1 the state is T_PRES, `busy`=1, `learn`=1, `in_cnt`=first pattern.
- Each presentation lasts exactly PRESENT_CYCLES cycles; each rest exactly REST_CYCLES cycles.
- A spike in the last I_PRES cycle is counted.
- `result_valid` rises 11 cycles after the last I_PRES cycle (10 EVAL + 1 REPORT).
- `done` pulses together with the transition to IDLE; `busy` falls on the same edge.

**Total run length**
- EPOCHS·NUM_PATTERNS·(PRESENT_CYCLES+REST_CYCLES) + NUM_PATTERNS·(PRESENT_CYCLES+11+REST_CYCLES) cycles.

**Registering**
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

`SNN_SCHED_SHUFFLE_EN`:
- **Defined:** a 4-bit maximal LFSR (x^4+x^3+1, seed 4'b1001 at reset) advances once per training epoch.
  - Training presents pattern (index + lfsr) mod NUM_PATTERNS, so order rotates per epoch.
  - Inference order stays sequential 0..NUM_PATTERNS-1.
- **Undefined:** training order is 0..NUM_PATTERNS-1 every epoch, and no LFSR logic is present.

## Test plan

Bench parameters unless stated otherwise: PRESENT_CYCLES=4, REST_CYCLES=2, NUM_PATTERNS=3, EPOCHS=2, CNT_W=4.

1. Reset/idle: hold `rst_n`=0, then release with no `start` → `in_cnt`=4'hF, `learn`=0, `busy`=0, `result_neuron`=4'hF for 100 cycles.
2. Training sequence (macro undefined): pulse `start` → `in_cnt` sequence 0,F,1,F,2,F repeated twice; `learn`=1 exactly 4 cycles per presentation; I_PRES begins at cycle 37 after `start`.
3. Winner and tie: drive spike[3] and spike[7] 3 times each during pattern 1 inference → `result_pattern`=1, `result_neuron`=3, `result_count`=3, `result_valid` for one cycle.
4. Saturation and no-spike: drive spike[9] every cycle with PRESENT_CYCLES=20 → `result_count`=15, `result_neuron`=9; for a pattern with no spikes → `result_neuron`=4'hF, `result_count`=0.
5. Start while busy and reset mid-run: pulse `start` during T_REST → no effect on sequence; assert `rst_n`=0 during I_PRES → same-cycle `busy`=0, `in_cnt`=4'hF, no `done`.
6. Shuffle (macro defined): training epoch orders match the LFSR model mod 3; `done` pulses once after 3 results.
